// File: rtl/apb_fifo_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the FIFO feeder.
package apb_fifo_pkg;

  localparam logic [7:0]  ADDR_CTRL   = 8'h00;
  localparam logic [7:0]  ADDR_STATUS = 8'h04;
  localparam logic [7:0]  ADDR_WDATA  = 8'h08;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;

  // Value written to CTRL once per reset to switch the peripheral on
  localparam logic [31:0] CTRL_ENABLE = 32'h0000_0001;

  typedef enum logic [2:0] {
    StInitSetup,
    StInitAccess,
    StIdle,
    StPollSetup,
    StPollAccess,
    StBackoff,
    StWrSetup,
    StWrAccess
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins, wrapping N_REQ-1 -> 0.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] rot;
  logic               found;
  int unsigned        slot;

  // Rotate the request vector so the pointer lands at bit 0, then pick the lowest set bit
  always_comb begin
    rot   = {req_i, req_i} >> ptr_i;
    found = 1'b0;
    idx_o = ptr_i;
    slot  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        slot  = 32'(ptr_i) + i;
        if (slot >= N_REQ) slot = slot - N_REQ;
        idx_o = IW'(slot);
      end
    end
    gnt_o = found ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/apb_fifo_feeder.sv
// APB master that enables the FIFO peripheral once, then polls STATUS and pushes one
// round-robin-arbitrated requester byte per WDATA write.
module apb_fifo_feeder
  import apb_fifo_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned BACKOFF = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     cfg_en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [7:0]               PADDR,
  output logic [31:0]              PWDATA,
  input  logic [31:0]              PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [15:0]              err_count
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BACKOFF + 1);

  state_e          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [7:0]      paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   bo_cnt_q, bo_cnt_d;
  logic [15:0]     err_q, err_d;

  logic            feed;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [DW-1:0]   arb_data;
  logic            unused_inputs;

  assign feed     = cfg_en & (|req_valid);
  assign arb_data = req_data[arb_idx*DW +: DW];

  // Only the FULL bit of STATUS steers the FSM; the one-hot grant is not needed here
  assign unused_inputs = ^{PRDATA[31:2], PRDATA[STATUS_EMPTY_BIT], arb_gnt};

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Next state plus next values of the registered APB outputs
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    bo_cnt_d  = bo_cnt_q;
    unique case (state_q)
      // psel_q low means the one-time CTRL write is still waiting for cfg_en
      StInitSetup: begin
        if (psel_q) begin
          state_d   = StInitAccess;
          penable_d = 1'b1;
        end else if (cfg_en) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = ADDR_CTRL;
          pwdata_d = CTRL_ENABLE;
        end
      end
      StInitAccess: begin
        if (PREADY) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      StIdle: begin
        if (feed) begin
          state_d  = StPollSetup;
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = ADDR_STATUS;
        end
      end
      StPollSetup: begin
        state_d   = StPollAccess;
        penable_d = 1'b1;
      end
      StPollAccess: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          // A slave error on the poll is treated like FULL
          if (PRDATA[STATUS_FULL_BIT] || PSLVERR) begin
            state_d  = StBackoff;
            bo_cnt_d = '0;
          end else if (feed) begin
            state_d  = StWrSetup;
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = ADDR_WDATA;
            pwdata_d = 32'(arb_data);
            grant_d  = arb_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBackoff: begin
        if (!feed) begin
          state_d = StIdle;
        end else if (bo_cnt_q == CW'(BACKOFF - 1)) begin
          state_d  = StPollSetup;
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = ADDR_STATUS;
        end else begin
          bo_cnt_d = bo_cnt_q + CW'(1);
        end
      end
      StWrSetup: begin
        state_d   = StWrAccess;
        penable_d = 1'b1;
      end
      StWrAccess: begin
        if (PREADY) begin
          penable_d = 1'b0;
          ptr_d     = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
          if (feed) begin
            state_d  = StPollSetup;
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
            paddr_d  = ADDR_STATUS;
          end else begin
            state_d = StIdle;
            psel_d  = 1'b0;
          end
        end
      end
      default: state_d = StInitSetup;
    endcase
  end

  // Saturating count of PSLVERR seen on completing access phases
  always_comb begin
    err_d = err_q;
    if (psel_q && penable_q && PREADY && PSLVERR && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // State and APB output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= StInitSetup;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      bo_cnt_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      bo_cnt_q  <= bo_cnt_d;
      err_q     <= err_d;
    end
  end

  // Handshake pulse to the granted requester as its WDATA write completes
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == StWrAccess) && PREADY && (grant_q == IW'(i));
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign grant_id  = grant_q;
  assign err_count = err_q;
  // Pending-enable cycles after reset do not count as busy
  assign busy      = (state_q != StIdle) && !((state_q == StInitSetup) && !psel_q);

endmodule

// File: tb/tb_apb_fifo_feeder.sv
// Bench for apb_fifo_feeder: producer queues, APB slave stub, transaction scoreboard and
// directed scenarios with hand-computed timing.
module tb_apb_fifo_feeder;
  import apb_fifo_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic            cfg_en = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            PSEL, PENABLE, PWRITE;
  logic [7:0]      PADDR;
  logic [31:0]     PWDATA, PRDATA;
  logic            PREADY, PSLVERR;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     err_count;

  apb_fifo_feeder #(
    .N_REQ   (N),
    .DW      (DW),
    .BACKOFF (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cfg_en    (cfg_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_count (err_count)
  );

  initial forever #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB slave stub ----------------
  int   polls_seen = 0;
  int   full_until = 0;
  int   wait_cnt = 0;
  int   wr_wait = 0;
  logic wr_err = 1'b0;

  assign PRDATA  = (polls_seen < full_until) ? 32'(1 << STATUS_FULL_BIT) : 32'h0;
  assign PREADY  = !(PSEL && PENABLE && (PADDR == ADDR_WDATA) && (wait_cnt < wr_wait));
  assign PSLVERR = PSEL && PENABLE && (PADDR == ADDR_WDATA) && wr_err;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (PSEL && PENABLE && PREADY && !PWRITE && (PADDR == ADDR_STATUS))
      polls_seen <= polls_seen + 1;
  end

  // ---------------- producers: valid while their queue holds a byte ----------------
  logic [7:0] src_mem [N][8];
  int         src_wr [N];
  int         src_rd [N];
  logic [N-1:0] seen;

  task automatic push(input int r, input logic [7:0] b);
    src_mem[r][src_wr[r] % 8] = b;
    src_wr[r]++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge PCLK);
      seen = req_ready;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (seen[i]) src_rd[i]++;
        req_valid[i] = (src_rd[i] != src_wr[i]);
        req_data[i*DW +: DW] = src_mem[i][src_rd[i] % 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
    int          gid;
  } txn_t;

  txn_t exp_q[$];
  int   wr_cyc[$];
  int   poll_cyc[$];
  int   model_err = 0;

  task automatic exp_txn(input logic [7:0] a, input logic w, input logic [31:0] d, input int g);
    txn_t t;
    t.addr = a;
    t.wr   = w;
    t.data = d;
    t.gid  = g;
    exp_q.push_back(t);
  endtask

  task automatic exp_poll();
    exp_txn(ADDR_STATUS, 1'b0, 32'h0, 0);
  endtask

  task automatic exp_byte(input logic [7:0] b, input int g);
    exp_txn(ADDR_WDATA, 1'b1, 32'(b), g);
  endtask

  txn_t         cur;
  logic [N-1:0] exp_rdy;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_addr;
  logic [31:0]  prev_wdata;
  logic         prev_write;

  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_stall = 1'b0;
        model_err  = 0;
      end else begin
        if (PENABLE) chk("penable_without_psel", PSEL, 1);
        if (prev_stall) begin
          chk("stall_psel_penable", {PSEL, PENABLE}, 2'b11);
          chk("stall_paddr", PADDR, prev_addr);
          chk("stall_pwdata", PWDATA, prev_wdata);
          chk("stall_pwrite", PWRITE, prev_write);
        end
        chk("err_count", err_count, model_err);
        if (PSEL && PENABLE && PREADY) begin
          chk("txn_pending", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("txn_addr", PADDR, cur.addr);
            chk("txn_write", PWRITE, cur.wr);
            if (cur.wr) chk("txn_wdata", PWDATA, cur.data);
            exp_rdy = (cur.wr && cur.addr == ADDR_WDATA) ? (N'(1) << cur.gid) : '0;
            chk("req_ready_on_done", req_ready, exp_rdy);
            if (cur.wr && cur.addr == ADDR_WDATA) chk("grant_id", grant_id, cur.gid);
          end
          if (PADDR == ADDR_WDATA) wr_cyc.push_back(cyc);
          if (PADDR == ADDR_STATUS) poll_cyc.push_back(cyc);
          if (PSLVERR && model_err < 16'hFFFF) model_err++;
        end else begin
          chk("req_ready_quiet", req_ready, 0);
        end
        prev_stall = PSEL && PENABLE && !PREADY;
        prev_addr  = PADDR;
        prev_wdata = PWDATA;
        prev_write = PWRITE;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge PCLK);
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    chk({name, "_completes"}, (n < 300), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int base;
  int n;

  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset values, with cfg_en still low (enable pending)
    @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    repeat (2) @(negedge PCLK);
    chk("pending_no_psel", PSEL, 0);

    // One-time enable write of CTRL
    exp_txn(ADDR_CTRL, 1'b1, 32'h1, 0);
    @(posedge PCLK);
    #1 cfg_en = 1'b1;
    wait_idle("init");
    chk("init_then_idle_busy", busy, 0);

    // All four requesters valid: grants 0,1,2,3,0 at one write per 4 cycles
    base = wr_cyc.size();
    for (int i = 0; i < 5; i++) begin
      exp_poll();
      exp_byte(8'h10 + 8'(i), i % 4);
    end
    exp_poll();
    @(negedge PCLK);
    push(0, 8'h10);
    push(0, 8'h14);
    push(1, 8'h11);
    push(2, 8'h12);
    push(3, 8'h13);
    wait_idle("rr");
    chk("rr_write_count", wr_cyc.size() - base, 5);
    for (int i = 1; i < 5; i++) begin
      if (wr_cyc.size() > base + i) chk("rr_interval", wr_cyc[base+i] - wr_cyc[base+i-1], 4);
    end

    // Single requester 2, cycle-by-cycle latency
    exp_poll();
    exp_byte(8'hA5, 2);
    exp_poll();
    @(negedge PCLK);
    push(2, 8'hA5);
    @(posedge PCLK);
    #2;
    @(negedge PCLK);
    chk("lat_c0_psel", PSEL, 0);
    chk("lat_c0_busy", busy, 0);
    @(negedge PCLK);
    chk("lat_c1_sel_en", {PSEL, PENABLE}, 2'b10);
    chk("lat_c1_paddr", PADDR, 8'h04);
    chk("lat_c1_pwrite", PWRITE, 0);
    chk("lat_c1_busy", busy, 1);
    @(negedge PCLK);
    chk("lat_c2_sel_en", {PSEL, PENABLE}, 2'b11);
    chk("lat_c2_paddr", PADDR, 8'h04);
    @(negedge PCLK);
    chk("lat_c3_sel_en", {PSEL, PENABLE}, 2'b10);
    chk("lat_c3_paddr", PADDR, 8'h08);
    chk("lat_c3_pwdata", PWDATA, 32'h0000_00A5);
    chk("lat_c3_req_ready", req_ready, 4'b0000);
    @(negedge PCLK);
    chk("lat_c4_sel_en", {PSEL, PENABLE}, 2'b11);
    chk("lat_c4_req_ready", req_ready, 4'b0100);
    chk("lat_c4_grant_id", grant_id, 2);
    wait_idle("single");

    // STATUS reports FULL three times: 4 back-off cycles between polls
    base = poll_cyc.size();
    n = wr_cyc.size();
    full_until = polls_seen + 3;
    for (int i = 0; i < 4; i++) exp_poll();
    exp_byte(8'h5C, 1);
    exp_poll();
    @(negedge PCLK);
    push(1, 8'h5C);
    wait_idle("backoff");
    chk("bo_poll_count", poll_cyc.size() - base, 5);
    for (int i = 1; i < 4; i++) begin
      if (poll_cyc.size() > base + i) chk("bo_poll_interval", poll_cyc[base+i] - poll_cyc[base+i-1], 6);
    end
    if (poll_cyc.size() > base + 3 && wr_cyc.size() > n)
      chk("bo_write_after_4th_poll", wr_cyc[n] - poll_cyc[base+3], 2);

    // WDATA access stalled 3 cycles and completed with PSLVERR
    base = poll_cyc.size();
    n = wr_cyc.size();
    wr_wait = 3;
    wr_err = 1'b1;
    exp_poll();
    exp_byte(8'h3C, 3);
    exp_poll();
    @(negedge PCLK);
    push(3, 8'h3C);
    wait_idle("stall_err");
    if (poll_cyc.size() > base && wr_cyc.size() > n)
      chk("stall_write_latency", wr_cyc[n] - poll_cyc[base], 5);
    chk("stall_err_count", err_count, 1);
    wr_wait = 0;
    wr_err = 1'b0;

    // Reset in the middle of a WDATA access, then re-initialise
    wr_wait = 50;
    exp_poll();
    exp_byte(8'h77, 0);
    @(negedge PCLK);
    push(0, 8'h77);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(PSEL && PENABLE && PADDR == ADDR_WDATA) && n < 50);
    chk("rst_reach_wr_access", (n < 50), 1);
    #2;
    PRESET = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_async_psel", PSEL, 0);
    chk("rst_async_penable", PENABLE, 0);
    exp_txn(ADDR_CTRL, 1'b1, 32'h1, 0);
    exp_poll();
    exp_byte(8'h77, 0);
    exp_poll();
    repeat (2) @(posedge PCLK);
    #1;
    wr_wait = 0;
    PRESET = 1'b0;
    wait_idle("reinit");
    chk("reinit_err_count", err_count, 0);
    chk("all_txns_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_fifo_feeder.md
# apb_fifo_feeder

Sequences multiple byte producers into the APB asynchronous FIFO peripheral. It acts as an APB master on the PCLK domain and performs one-time enable of the peripheral via CTRL. It polls STATUS before every push and arbitrates round-robin among N valid/ready requesters. Each granted byte becomes one APB write to WDATA. It sits between on-chip producers and the FIFO's APB slave port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, requester data width (≤ 32)
- BACKOFF, 4, idle cycles between STATUS polls while FIFO full (≥ 1)
- PCLK  in  1  APB clock; the only clock
- PRESET  in  1  reset, asynchronous, active-high
- cfg_en  in  1  start/continue feeding; deassert = stop after current transfer
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*DW  packed bytes, requester i at [i*DW +: DW]
- req_ready  out  N_REQ  one-hot handshake pulse, byte consumed
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  8  APB address
- PWDATA  out  32  APB write data, DW zero-extended
- PRDATA  in  32  APB read data
- PREADY, PSLVERR  in  1 each  APB slave response
- grant_id  out  $clog2(N_REQ)  requester of transfer in flight
- busy  out  1  FSM not in IDLE
- err_count  out  16  saturating PSLVERR count

## Operation
- Register map: CTRL 0x00 (bit0 enable), STATUS 0x04 (bit0 EMPTY, bit1 FULL), WDATA 0x08.
- States: INIT_SETUP, INIT_ACCESS, IDLE, POLL_SETUP, POLL_ACCESS, BACKOFF, WR_SETUP, WR_ACCESS.
- After reset, first cycle with cfg_en=1: INIT_SETUP writes CTRL=0x1, then INIT_ACCESS. Done once per reset.
- IDLE: if cfg_en and any req_valid -> POLL_SETUP.
- POLL_ACCESS with PREADY: if PRDATA[1]=1 -> BACKOFF. Otherwise arbitrate, latch grant_id and byte, -> WR_SETUP.
- BACKOFF counts BACKOFF cycles, then -> POLL_SETUP. If cfg_en=0 or no req_valid, -> IDLE.
- WR_ACCESS with PREADY: req_ready[grant_id]=1 for that cycle. RR pointer = grant_id+1 mod N_REQ. Next state is POLL_SETUP if cfg_en and any valid, else IDLE.
- Arbitration: round-robin starting at pointer; wraps N_REQ-1 -> 0. Pointer resets to 0.
- Requester holds req_valid/req_data stable until req_ready. A byte is latched at grant; later changes are ignored.
- PSLVERR on any access phase: err_count +1, saturating at 0xFFFF. The byte is still retired (req_ready pulses). PSLVERR on a poll is treated as FULL.
- cfg_en falling mid-transfer: the current APB transfer completes, then the FSM goes to IDLE.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, grant_id=0, busy=0, err_count=0, state INIT_SETUP (pending enable).
- APB: setup phase 1 cycle (PSEL=1, PENABLE=0). Access phase holds PSEL=PENABLE=1 and stable PADDR/PWDATA/PWRITE until PREADY. All APB outputs are registered.
- req_ready is decoded combinationally: (state==WR_ACCESS) & PREADY & (grant_id==i).
- Latency with PREADY tied high: valid seen in IDLE at cycle 0. POLL_SETUP is cycle 1, POLL_ACCESS cycle 2, WR_SETUP cycle 3, WR_ACCESS/req_ready cycle 4.
- Back-to-back throughput: 1 byte per 4 cycles.
- PRESET mid-transfer clears PSEL/PENABLE asynchronously and re-arms INIT.

## Structure
- Package apb_fifo_pkg holds:
  - ADDR_CTRL/ADDR_STATUS/ADDR_WDATA
  - STATUS_EMPTY_BIT=0 and STATUS_FULL_BIT=1
  - the state enum
- Sub-module rr_arbiter, parameterised by N_REQ: inputs req and pointer, outputs one-hot grant and encoded index.

## Test plan
- Reset then cfg_en=1 -> one APB write to 0x00 with PWDATA=0x1, then IDLE, busy=0.
- Requester 2 valid with 0xA5, PREADY=1 -> STATUS read at 0x04. WDATA write 0x000000A5 at 0x08. req_ready[2] pulses in cycle 4.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0, one write per 4 cycles.
- STATUS returns 0x2 three times, then 0x0 -> BACKOFF of 4 cycles between polls. No write occurs until the 4th poll, and no req_ready pulses before it.
- PREADY low 3 cycles in WR_ACCESS -> PADDR/PWDATA stable throughout. PSLVERR=1 on completion -> err_count=1, req_ready still pulses.
- Drive PRESET during WR_ACCESS -> PSEL=0 immediately. After release, INIT write is reissued before any WDATA write.
